param_sync_fifo: RTL
====================

// Module: param_sync_fifo
// PURPOSE
//  Single-clock FIFO, next generation of the team's simple FIFO. Any depth (not only 2^N),
//  selectable standard or first-word-fall-through (FWFT) read mode, almost-full/empty
//  thresholds, fill-level output, sticky overflow/underflow error flags.
//  Sits between producer/consumer datapaths in one clock domain.
// PARAMETERS
//  DATA_WIDTH  8   word width in bits
//  DEPTH       16  number of entries; any integer >= 2
//  FWFT        0   0 = standard read (registered dout), 1 = first-word-fall-through
//  AF_THRESH   14  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH   2   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1                      clock, rising edge
//  rst           in   1                      synchronous, active-high reset
//  wr_en         in   1                      write request
//  din           in   DATA_WIDTH             write data
//  rd_en         in   1                      read request (pop in FWFT mode)
//  dout          out  DATA_WIDTH             read data
//  dout_valid    out  1                      dout holds a freshly read / head word
//  clr_err       in   1                      clears sticky error flags
//  count         out  $clog2(DEPTH+1)        current fill level
//  empty         out  1                      count == 0
//  full          out  1                      count == DEPTH
//  almost_empty  out  1                      count <= AE_THRESH
//  almost_full   out  1                      count >= AF_THRESH
//  overflow      out  1                      sticky: write attempted while full
//  underflow     out  1                      sticky: read attempted while empty
// BEHAVIOUR
//  - Reset: pointers=0, count=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=0, underflow=0. Memory contents not reset. Reset has priority
//    over all other inputs and aborts any in-flight operation.
//  - wr_acc = wr_en & !full; rd_acc = rd_en & !empty. Evaluated on pre-edge state.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (no power-of-two masking).
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//    Flags are registered/derived from count; all update the cycle after the access.
//  - Full + wr_en + rd_en: read accepted, write rejected, overflow set.
//  - Empty + wr_en + rd_en: write accepted, read rejected, underflow set.
//  - overflow set on wr_en & full; underflow set on rd_en & empty; both held until rst or
//    clr_err. clr_err coincident with a new error event: the set wins.
//  - FWFT=0: on rd_acc at edge N, dout = mem[rd_ptr] after edge N, dout_valid=1 for that
//    one cycle; otherwise dout holds last value, dout_valid=0. Read latency 1 cycle.
//  - FWFT=1: dout = head entry whenever !empty, dout_valid = !empty; rd_en pops head.
//    Word written at edge N is visible on dout with dout_valid=1 after edge N.
//    dout is a don't-care while empty.
//  - Write-to-empty-flag latency: 1 cycle in both modes.
//  - Elaboration check: DEPTH<2, AF_THRESH outside 1..DEPTH or AE_THRESH outside
//    0..DEPTH-1 -> $error.
// STRUCTURE
//  - Package fifo_pkg: function clog2_safe(), read-mode constants FIFO_STD=0, FIFO_FWFT=1.
//  - Sub-module fifo_sdp_ram: simple dual-port RAM, sync write, async read port;
//    top registers dout in standard mode.
//  - Top holds pointers, counter, flag logic, error flags.
// TESTING (DEPTH=5, DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1; run with FWFT=0 and FWFT=1)
//  1 Reset, then write 0x11..0x15 -> count=5, full=1, almost_full=1 from count 4;
//    read 5 -> data 0x11..0x15 in order, empty=1 at end.
//  2 Wrap: write 3, read 3, write 5 -> pointers wrap past index 4; readback is in order,
//    no data loss.
//  3 Full + wr_en + rd_en, din=0xAA -> head word popped, 0xAA dropped, count 5->4,
//    overflow=1.
//  4 Empty + wr_en=rd_en=1, din=0x3C -> count=1, underflow=1; 0x3C is the next read.
//    clr_err -> both flags 0.
//  5 FWFT=1: single write 0x7E -> next cycle dout=0x7E, dout_valid=1 with no rd_en.
//    FWFT=0: rd_en -> dout=0x7E one cycle later, dout_valid pulse of width 1.
//  6 rst asserted mid-burst with count=3 -> next cycle all outputs at reset values;
//    subsequent write/read returns only new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised sync FIFO.
// Provides read-mode selectors and a pointer-width helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width that stays >= 1 even for tiny depths.
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth, standard or FWFT read mode.
// Ports: clk/rst, wr_en/din, rd_en/dout/dout_valid, clr_err, count + status/error flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_valid,
    input  logic                         clr_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("param_sync_fifo: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("param_sync_fifo: AE_THRESH out of range");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    always_comb begin
        wr_acc   = wr_en & ~full;
        rd_acc   = rd_en & ~empty;
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error event beats a simultaneous clear.
        ovf_d = (wr_en & full) | (ovf_q & ~clr_err);
        udf_d = (rd_en & empty) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr_q),
        .wdata(din),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word shown directly; forced to 0 while empty so reset reads 0.
        assign dout       = empty ? '0 : ram_rdata;
        assign dout_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dv_q, dv_d;

        always_comb begin
            dout_d = rd_acc ? ram_rdata : dout_q;
            dv_d   = rd_acc;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dout_q <= dout_d;
                dv_q   <= dv_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dv_q;
    end

endmodule
